// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debouncer, press/release pulses, press counter.
// Optional long-hold pulse built when BTN_DEBOUNCE_LONGPRESS_EN is defined; otherwise long_press is tied 0.
// The release pulse port is named release_pulse because "release" is a reserved word in SystemVerilog.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press,
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic       long_press
);

  localparam logic        REL     = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 32'h00FF_FFFF || LONG_CYCLES == 0) begin : g_param_check
    $error("button_debounce: DEBOUNCE_CYCLES must be 1..2^24-1 and LONG_CYCLES >= 1");
  end

  logic        s1;
  logic        s2;
  logic [23:0] db_cnt;
  logic [23:0] db_cnt_next;
  logic        accept;
  logic        press_event;
  logic        release_event;

  // Any cycle where the synchronized input agrees with the accepted level restarts the count.
  always_comb begin
    db_cnt_next = '0;
    accept      = 1'b0;
    if (s2 != btn_level) begin
      if (db_cnt == DB_LAST) begin
        accept = 1'b1;
      end else begin
        db_cnt_next = db_cnt + 24'd1;
      end
    end
  end

  assign press_event   = accept && (s2 != REL);
  assign release_event = accept && (s2 == REL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1            <= REL;
      s2            <= REL;
      btn_level     <= REL;
      db_cnt        <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      s1            <= btn_raw;
      s2            <= s1;
      db_cnt        <= db_cnt_next;
      press         <= press_event;
      release_pulse <= release_event;
      if (accept) begin
        btn_level <= s2;
      end
      if (press_event) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

  logic [31:0] long_cnt;
  logic        long_done;

  // long_done stops the counter after the single pulse so a long hold fires only once per press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      long_cnt   <= '0;
      long_done  <= 1'b0;
      long_press <= 1'b0;
    end else if (press_event || (btn_level == REL)) begin
      long_cnt   <= '0;
      long_done  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!long_done) begin
        if (long_cnt == LONG_LAST) begin
          long_press <= 1'b1;
          long_done  <= 1'b1;
        end else begin
          long_cnt <= long_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Conditions one raw mechanical push-button input before it reaches the PIO input-port slave.
- Input path: 2-flop synchronizer, then a counter-based debouncer.
- btn_level is the clean level that drives the PIO slave's in_port.
- Also produces single-cycle press/release pulses and a wrapping press counter for local logic.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^24-1
ACTIVE_LOW, 1, 1 = pressed when raw is 0 (DE-board KEY); 0 = pressed when raw is 1
LONG_CYCLES, 50000000, hold time after accepted press before long_press fires (used only with optional feature)

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
btn_raw  input  1  unsynchronized push-button pin
btn_level  output  1  debounced level, same polarity as btn_raw; feeds PIO in_port
press  output  1  one-cycle pulse when debounced level enters the pressed state
release  output  1  one-cycle pulse when debounced level enters the released state
press_count  output  8  number of accepted presses, modulo 256
long_press  output  1  one-cycle long-hold pulse (optional feature; otherwise constant 0)

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- REL denotes the released level, REL = ACTIVE_LOW ? 1 : 0.
- Reset values (asserted asynchronously):
  - s1, s2, btn_level = REL
  - debounce counter = 0, press_count = 0
  - press, release, long_press = 0
  - long counter = 0
- Synchronizer: s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
- Debounce counter: 24 bits wide. On every edge:
  - if s2 == btn_level: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: btn_level <= s2, counter <= 0.
  - else: counter <= counter+1.
- Latency: btn_raw stable at a new value from edge k changes btn_level after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges.
- Glitch rejection:
  - Any single cycle with s2 == btn_level restarts the count from 0.
  - A bounce train shorter than DEBOUNCE_CYCLES never changes btn_level.
- Pulses: press and release are registered. They are asserted on the same edge that btn_level changes and held for exactly one cycle.
  - press when the new level != REL.
  - release when the new level == REL.
  - press and release are never high together.
- press_count: increments on the same edge press asserts; 255 wraps to 0; no saturation.
- DEBOUNCE_CYCLES=1: btn_level follows s2 one edge later; counter stays 0.
- Reset mid-count: all state returns to reset values immediately; no pulse is emitted.
  - If the button is held through reset, it is re-accepted as a press DEBOUNCE_CYCLES+2 edges after reset release.

Optional Feature:
Macro BTN_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - 32-bit long counter clears on press and while btn_level == REL.
  - Counts while pressed.
  - When it reaches LONG_CYCLES-1, long_press pulses for one cycle and the counter stops (one pulse per press).
  - release before then gives no pulse.
- Undefined:
  - No long counter is built; long_press is tied 0.
  - Port list is identical in both builds.

Test Plan:
- Reset with btn_raw=1, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4 -> btn_level=1, press=release=0, press_count=0 during and after reset.
- Drive btn_raw 1->0 at edge k, hold -> btn_level=0 after edge k+6; press high exactly one cycle at that edge; press_count=1.
- Bounce 0/1 with runs of 3 cycles for 40 cycles, then settle at 1 -> no change or pulses during the bounce; release pulse 6 edges after settling; press_count unchanged.
- 257 clean presses -> press_count=1 (wrap); 257 press pulses and 257 release pulses counted.
- Assert reset_n=0 mid-count (counter=2) while pressed, then release reset with the button still held -> outputs at reset values; single press 6 edges after reset release.
- With BTN_DEBOUNCE_LONGPRESS_EN, LONG_CYCLES=10, hold 30 cycles -> exactly one long_press, 10 edges after press. Release at 5 cycles -> none. Macro undefined -> long_press constantly 0.
